// File: rtl/serial_pkg.sv
// Shared types and sizing helpers for the ADC-to-UART sample sequencer.
// Holds the FSM encoding, frame geometry and counter-width helper.
package serial_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CONV  = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
        ST_STOP  = 3'd4
    } state_e;

    localparam int FRAME_BITS = 10;
    localparam int DATA_BITS  = 8;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running modulo-DIV counter that pulses tick on its last count.
// Dropping run clears the count so the next run starts from zero.
module tick_divider
    import serial_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tick
);

    localparam int W = cnt_width(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: wrap at LAST, hold at zero while stopped.
    always_comb begin
        cnt_d = '0;
        if (run) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = run && (cnt_q == LAST);

endmodule

// File: rtl/adc_serial_sequencer.sv
// Periodic ADC conversion followed by an 8N1 transmit of the sample.
// Reports sample ticks that land mid-cycle and ADCs that never answer.
module adc_serial_sequencer
    import serial_pkg::*;
#(
    parameter int CLK_HZ      = 50000000,
    parameter int BAUD        = 9600,
    parameter int SAMPLE_DIV  = 50000,
    parameter int ADC_TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    output logic       adc_start,
    input  logic       adc_done,
    input  logic [7:0] adc_data,
    output logic       tx,
    output logic       busy,
    output logic       frame_done,
    output logic       overrun,
    output logic       timeout_err
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int WAIT_W = cnt_width(ADC_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ADC_TIMEOUT - 1);
    localparam logic [2:0] IDX_LAST = 3'(DATA_BITS - 1);

    state_e               state_q, state_d;
    logic [WAIT_W-1:0]    wait_q, wait_d;
    logic [2:0]           idx_q, idx_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 tx_q, tx_d;
    logic                 start_q, start_d;
    logic                 done_q, done_d;
    logic                 ovr_q, ovr_d;
    logic                 tmo_q, tmo_d;

    logic tick;
    logic bit_end;
    logic in_frame;

    // The baud timer only runs on the wire, so entering START restarts it.
    assign in_frame = state_q inside {ST_START, ST_DATA, ST_STOP};

    tick_divider #(.DIV(SAMPLE_DIV)) u_sample_tmr (
        .clk  (clk),
        .rst  (rst),
        .run  (enable),
        .tick (tick)
    );

    tick_divider #(.DIV(CLKS_PER_BIT)) u_baud_tmr (
        .clk  (clk),
        .rst  (rst),
        .run  (in_frame),
        .tick (bit_end)
    );

    // Next-state, latch and output logic; tx follows the next state so
    // the registered line lines up with the state register.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        idx_d   = idx_q;
        data_d  = data_q;
        start_d = 1'b0;
        done_d  = 1'b0;
        tmo_d   = tmo_q;
        ovr_d   = ovr_q | (tick && (state_q != ST_IDLE));

        unique case (state_q)
            ST_IDLE: begin
                wait_d = '0;
                if (tick) begin
                    state_d = ST_CONV;
                    start_d = 1'b1;
                end
            end
            ST_CONV: begin
                if (adc_done) begin
                    data_d  = adc_data;
                    state_d = ST_START;
                end else if (wait_q == WAIT_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                    idx_d   = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        tx_d = 1'b1;
        if (state_d == ST_START) begin
            tx_d = 1'b0;
        end else if (state_d == ST_DATA) begin
            tx_d = data_d[idx_d];
        end
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            wait_q  <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            tx_q    <= 1'b1;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            tx_q    <= tx_d;
            start_q <= start_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
            tmo_q   <= tmo_d;
        end
    end

    assign adc_start   = start_q;
    assign tx          = tx_q;
    assign busy        = (state_q != ST_IDLE);
    assign frame_done  = done_q;
    assign overrun     = ovr_q;
    assign timeout_err = tmo_q;

endmodule
